// File: rtl/mac_stream_seq.sv
// Tile sequencer for a MAC engine fed by three TCDM streams (A, B, C).
// It walks n_tiles tiles, starting every stream for each tile and waiting for all of them to finish.
module mac_stream_seq #(
    parameter int TW = 8,
    parameter int AW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [TW-1:0] n_tiles_i,
    input  logic [AW-1:0] a_base_i,
    input  logic [AW-1:0] b_base_i,
    input  logic [AW-1:0] c_base_i,
    input  logic [AW-1:0] a_stride_i,
    input  logic [AW-1:0] b_stride_i,
    input  logic [AW-1:0] c_stride_i,
    output logic          a_req_start_o,
    output logic          b_req_start_o,
    output logic          c_req_start_o,
    output logic [AW-1:0] a_addr_o,
    output logic [AW-1:0] b_addr_o,
    output logic [AW-1:0] c_addr_o,
    input  logic          a_ready_start_i,
    input  logic          b_ready_start_i,
    input  logic          c_ready_start_i,
    input  logic          a_done_i,
    input  logic          b_done_i,
    input  logic          c_done_i,
    output logic          engine_clear_o,
    output logic          engine_enable_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [TW-1:0] tile_idx_o
);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, RUN, NEXT, FINISH} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] n_tiles_q, n_tiles_d;
    logic [TW-1:0] tile_idx_q, tile_idx_d;
    logic [AW-1:0] base_q [3];
    logic [AW-1:0] base_d [3];
    logic [AW-1:0] stride_q [3];
    logic [AW-1:0] stride_d [3];
    logic [AW-1:0] addr_q [3];
    logic [AW-1:0] addr_d [3];
    logic [2:0]    issued_q, issued_d;
    logic [2:0]    doneflag_q, doneflag_d;
    logic [2:0]    req_q, req_d;
    logic          eng_clear_q, eng_clear_d;
    logic          eng_en_q, eng_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [AW-1:0] base_in [3];
    logic [AW-1:0] stride_in [3];
    logic [2:0]    ready_s;
    logic [2:0]    done_s;
    logic [2:0]    hs_s;

    assign base_in[0]   = a_base_i;
    assign base_in[1]   = b_base_i;
    assign base_in[2]   = c_base_i;
    assign stride_in[0] = a_stride_i;
    assign stride_in[1] = b_stride_i;
    assign stride_in[2] = c_stride_i;
    assign ready_s      = {c_ready_start_i, b_ready_start_i, a_ready_start_i};
    assign done_s       = {c_done_i, b_done_i, a_done_i};
    assign hs_s         = req_q & ready_s;

    always_comb begin
        state_d    = state_q;
        n_tiles_d  = n_tiles_q;
        tile_idx_d = tile_idx_q;
        base_d     = base_q;
        stride_d   = stride_q;
        addr_d     = addr_q;
        issued_d   = issued_q;
        doneflag_d = doneflag_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    n_tiles_d = n_tiles_i;
                    for (int i = 0; i < 3; i++) begin
                        base_d[i]   = base_in[i];
                        stride_d[i] = stride_in[i];
                    end
                    state_d = (n_tiles_i != '0) ? LOAD : FINISH;
                end
            end
            LOAD: begin
                addr_d     = base_q;
                tile_idx_d = '0;
                issued_d   = '0;
                doneflag_d = '0;
                state_d    = ISSUE;
            end
            ISSUE: begin
                // A handshake in this cycle already counts towards leaving ISSUE.
                issued_d   = issued_q | hs_s;
                doneflag_d = doneflag_q | done_s;
                if (issued_d == 3'b111) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                doneflag_d = doneflag_q | done_s;
                if (doneflag_q == 3'b111) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                doneflag_d = doneflag_q | done_s;
                if (tile_idx_q == n_tiles_q - TW'(1)) begin
                    state_d = FINISH;
                end else begin
                    tile_idx_d = tile_idx_q + TW'(1);
                    for (int i = 0; i < 3; i++) begin
                        addr_d[i] = addr_q[i] + stride_q[i];
                    end
                    issued_d   = '0;
                    doneflag_d = '0;
                    state_d    = ISSUE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear_i) begin
            state_d    = IDLE;
            tile_idx_d = '0;
            issued_d   = '0;
            doneflag_d = '0;
            for (int i = 0; i < 3; i++) begin
                addr_d[i] = '0;
            end
        end

        // Outputs are decoded from the next state so they come straight off flops.
        req_d       = (state_d == ISSUE) ? ~issued_d : 3'b000;
        eng_clear_d = (state_d == LOAD);
        eng_en_d    = (state_d == ISSUE) || (state_d == RUN);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FINISH);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            n_tiles_q   <= '0;
            tile_idx_q  <= '0;
            issued_q    <= '0;
            doneflag_q  <= '0;
            req_q       <= '0;
            eng_clear_q <= 1'b0;
            eng_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                base_q[i]   <= '0;
                stride_q[i] <= '0;
                addr_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            n_tiles_q   <= n_tiles_d;
            tile_idx_q  <= tile_idx_d;
            issued_q    <= issued_d;
            doneflag_q  <= doneflag_d;
            req_q       <= req_d;
            eng_clear_q <= eng_clear_d;
            eng_en_q    <= eng_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int i = 0; i < 3; i++) begin
                base_q[i]   <= base_d[i];
                stride_q[i] <= stride_d[i];
                addr_q[i]   <= addr_d[i];
            end
        end
    end

    assign a_req_start_o   = req_q[0];
    assign b_req_start_o   = req_q[1];
    assign c_req_start_o   = req_q[2];
    assign a_addr_o        = addr_q[0];
    assign b_addr_o        = addr_q[1];
    assign c_addr_o        = addr_q[2];
    assign engine_clear_o  = eng_clear_q;
    assign engine_enable_o = eng_en_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign tile_idx_o      = tile_idx_q;

    // A pending request must never see its address move underneath it.
    for (genvar g = 0; g < 3; g++) begin : g_addr_stable
        a_addr_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (req_q[g] && $past(req_q[g])) |-> $stable(addr_q[g]));
    end

endmodule

// File: tb/tb_mac_stream_seq.sv
// Scoreboard bench for mac_stream_seq: directed jobs push expected stream addresses and done tile indices,
// a monitor pops and compares them on every accepted start and every done_o pulse.
module tb_mac_stream_seq;

    localparam int TW = 8;
    localparam int AW = 32;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          start;
    logic [TW-1:0] nTiles;
    logic [AW-1:0] aBase, bBase, cBase, aStride, bStride, cStride;
    logic          aReq, bReq, cReq;
    logic [AW-1:0] aAddr, bAddr, cAddr;
    logic [2:0]    readyVec;
    logic [2:0]    autoPulse;
    logic [2:0]    manPulse;
    logic [2:0]    doneVec;
    logic [2:0]    autoEn;
    logic          engClear, engEnable, busy, done;
    logic [TW-1:0] tileIdx;

    int total = 0;
    int bad   = 0;
    int dly   = 5;

    logic [AW-1:0] qA[$];
    logic [AW-1:0] qB[$];
    logic [AW-1:0] qC[$];
    logic [TW-1:0] qDone[$];

    assign doneVec = autoPulse | manPulse;

    mac_stream_seq #(.TW(TW), .AW(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .n_tiles_i(nTiles),
        .a_base_i(aBase), .b_base_i(bBase), .c_base_i(cBase),
        .a_stride_i(aStride), .b_stride_i(bStride), .c_stride_i(cStride),
        .a_req_start_o(aReq), .b_req_start_o(bReq), .c_req_start_o(cReq),
        .a_addr_o(aAddr), .b_addr_o(bAddr), .c_addr_o(cAddr),
        .a_ready_start_i(readyVec[0]), .b_ready_start_i(readyVec[1]), .c_ready_start_i(readyVec[2]),
        .a_done_i(doneVec[0]), .b_done_i(doneVec[1]), .c_done_i(doneVec[2]),
        .engine_clear_o(engClear), .engine_enable_o(engEnable),
        .busy_o(busy), .done_o(done), .tile_idx_o(tileIdx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [TW-1:0] n,
                                 input logic [AW-1:0] ab, input logic [AW-1:0] bb, input logic [AW-1:0] cb,
                                 input logic [AW-1:0] as, input logic [AW-1:0] bs, input logic [AW-1:0] cs);
        @(posedge clk);
        #1;
        nTiles  = n;
        aBase   = ab;
        bBase   = bb;
        cBase   = cb;
        aStride = as;
        bStride = bs;
        cStride = cs;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput("done_seen", {63'd0, seen}, 64'd1);
    endtask

    task automatic checkDrained(input string name);
        checkOutput(name, 64'(qA.size() + qB.size() + qC.size() + qDone.size()), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        clear     = 1'b0;
        start     = 1'b0;
        nTiles    = '0;
        aBase     = '0;
        bBase     = '0;
        cBase     = '0;
        aStride   = '0;
        bStride   = '0;
        cStride   = '0;
        readyVec  = 3'b111;
        autoPulse = 3'b000;
        manPulse  = 3'b000;
        autoEn    = 3'b111;

        fork
            // Monitor: every accepted start and every done_o pops one expectation.
            forever begin
                logic [63:0] exp;
                @(negedge clk);
                if (rst_n) begin
                    if (aReq && readyVec[0]) begin
                        exp = (qA.size() > 0) ? 64'(qA.pop_front()) : 'x;
                        checkOutput("a_addr_at_accept", 64'(aAddr), exp);
                    end
                    if (bReq && readyVec[1]) begin
                        exp = (qB.size() > 0) ? 64'(qB.pop_front()) : 'x;
                        checkOutput("b_addr_at_accept", 64'(bAddr), exp);
                    end
                    if (cReq && readyVec[2]) begin
                        exp = (qC.size() > 0) ? 64'(qC.pop_front()) : 'x;
                        checkOutput("c_addr_at_accept", 64'(cAddr), exp);
                    end
                    if (done) begin
                        exp = (qDone.size() > 0) ? 64'(qDone.pop_front()) : 'x;
                        checkOutput("done_tile_idx", 64'(tileIdx), exp);
                    end
                end
            end
            // Stream responder: pulse done dly cycles after each accepted start.
            begin
                logic [2:0] pend;
                int cnt [3];
                for (int i = 0; i < 3; i++) cnt[i] = 0;
                forever begin
                    @(negedge clk);
                    pend = {cReq & readyVec[2], bReq & readyVec[1], aReq & readyVec[0]} & autoEn & {3{rst_n}};
                    @(posedge clk);
                    #1;
                    for (int i = 0; i < 3; i++) begin
                        autoPulse[i] = 1'b0;
                        if (!rst_n) begin
                            cnt[i] = 0;
                        end else if (pend[i]) begin
                            cnt[i] = dly;
                        end else if (cnt[i] > 0) begin
                            cnt[i] = cnt[i] - 1;
                            autoPulse[i] = (cnt[i] == 0);
                        end
                    end
                end
            end
        join_none

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_req", {61'd0, cReq, bReq, aReq}, 64'd0);
        checkOutput("rst_ctrl", {60'd0, engClear, engEnable, busy, done}, 64'd0);
        checkOutput("rst_addr_a", 64'(aAddr), 64'd0);
        checkOutput("rst_addr_c", 64'(cAddr), 64'd0);
        checkOutput("rst_tile", 64'(tileIdx), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-tile job finishes immediately
        qDone.push_back(8'd0);
        applyStimulus(8'd0, 32'h100, 32'h200, 32'h300, 32'h40, 32'h40, 32'h80);
        @(negedge clk);
        checkOutput("zero_done", {63'd0, done}, 64'd1);
        checkOutput("zero_busy", {63'd0, busy}, 64'd1);
        checkOutput("zero_no_clear", {63'd0, engClear}, 64'd0);
        checkOutput("zero_no_req", {61'd0, cReq, bReq, aReq}, 64'd0);
        @(negedge clk);
        checkOutput("zero_idle", {62'd0, busy, done}, 64'd0);
        checkDrained("zero_drained");

        // Three tiles, all streams ready, plus a start pulse mid-job that must be ignored
        qA.push_back(32'h100); qA.push_back(32'h140); qA.push_back(32'h180);
        qB.push_back(32'h200); qB.push_back(32'h240); qB.push_back(32'h280);
        qC.push_back(32'h300); qC.push_back(32'h380); qC.push_back(32'h400);
        qDone.push_back(8'd2);
        applyStimulus(8'd3, 32'h100, 32'h200, 32'h300, 32'h40, 32'h40, 32'h80);
        @(negedge clk);
        checkOutput("lat_engine_clear", {63'd0, engClear}, 64'd1);
        checkOutput("lat_busy", {63'd0, busy}, 64'd1);
        checkOutput("lat_no_req_yet", {61'd0, cReq, bReq, aReq}, 64'd0);
        @(negedge clk);
        checkOutput("lat_req", {61'd0, cReq, bReq, aReq}, 64'd7);
        checkOutput("lat_enable", {62'd0, engClear, engEnable}, 64'd1);
        checkOutput("lat_tile0", 64'(tileIdx), 64'd0);
        applyStimulus(8'd1, 32'h900, 32'h900, 32'h900, 32'h0, 32'h0, 32'h0);
        waitDone(200);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("three_idle_after", {62'd0, busy, done}, 64'd0);
        end
        checkDrained("three_drained");

        // Stream B stalls; A and C must still be issued once each
        readyVec = 3'b101;
        qA.push_back(32'h10); qB.push_back(32'h20); qC.push_back(32'h30);
        qDone.push_back(8'd0);
        applyStimulus(8'd1, 32'h10, 32'h20, 32'h30, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("b_req_held", {63'd0, bReq}, 64'd1);
            checkOutput("no_done_while_b_stalled", {63'd0, done}, 64'd0);
            if (i > 0) begin
                checkOutput("a_req_dropped", {63'd0, aReq}, 64'd0);
                checkOutput("c_req_dropped", {63'd0, cReq}, 64'd0);
            end
        end
        @(posedge clk);
        #1 readyVec = 3'b111;
        waitDone(60);
        @(negedge clk);
        checkOutput("stall_idle", {63'd0, busy}, 64'd0);
        checkDrained("stall_drained");

        // a_done arrives in ISSUE before C is accepted
        autoEn   = 3'b000;
        readyVec = 3'b011;
        qA.push_back(32'h400); qB.push_back(32'h500); qC.push_back(32'h600);
        qDone.push_back(8'd0);
        applyStimulus(8'd1, 32'h400, 32'h500, 32'h600, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1 manPulse = 3'b001;
        @(posedge clk); #1 manPulse = 3'b000;
        @(negedge clk);
        checkOutput("early_done_c_pending", {61'd0, cReq, bReq, aReq}, 64'd4);
        @(posedge clk); #1 readyVec = 3'b111;
        @(posedge clk);
        @(posedge clk); #1 manPulse = 3'b100;
        @(posedge clk); #1 manPulse = 3'b010;
        @(posedge clk); #1 manPulse = 3'b000;
        waitDone(20);
        @(negedge clk);
        checkOutput("early_idle", {63'd0, busy}, 64'd0);
        checkDrained("early_drained");

        // Address wraps modulo 2^AW on the second tile
        autoEn = 3'b111;
        qA.push_back(32'hFFFF_FFC0); qA.push_back(32'h0000_0000);
        qB.push_back(32'h0); qB.push_back(32'h4);
        qC.push_back(32'h10); qC.push_back(32'h14);
        qDone.push_back(8'd1);
        applyStimulus(8'd2, 32'hFFFF_FFC0, 32'h0, 32'h10, 32'h40, 32'h4, 32'h4);
        waitDone(100);
        @(negedge clk);
        checkDrained("wrap_drained");

        // clear_i in RUN aborts the job; a start pulse while busy is ignored
        qA.push_back(32'h1000); qB.push_back(32'h2000); qC.push_back(32'h3000);
        applyStimulus(8'd2, 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h100, 32'h100);
        applyStimulus(8'd5, 32'h5000, 32'h6000, 32'h7000, 32'h10, 32'h10, 32'h10);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        checkOutput("clear_ctrl", {60'd0, engClear, engEnable, busy, done}, 64'd0);
        checkOutput("clear_req", {61'd0, cReq, bReq, aReq}, 64'd0);
        checkOutput("clear_tile", 64'(tileIdx), 64'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("clear_stays_idle", {62'd0, busy, done}, 64'd0);
        end
        checkDrained("clear_drained");

        // Asynchronous reset mid-job
        readyVec = 3'b000;
        applyStimulus(8'd1, 32'h700, 32'h800, 32'h900, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_mid_req_before", {61'd0, cReq, bReq, aReq}, 64'd7);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_req", {61'd0, cReq, bReq, aReq}, 64'd0);
        checkOutput("rst_mid_ctrl", {60'd0, engClear, engEnable, busy, done}, 64'd0);
        checkOutput("rst_mid_addr", 64'(aAddr), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        readyVec = 3'b111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("rst_mid_quiet", {59'd0, cReq, bReq, aReq, busy, done}, 64'd0);
        end
        checkDrained("final_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
